// File: rtl/writeback.sv
// writeback.sv -- final (WB) pipeline stage and register-file write port into decode.
// Completes memory-stage instructions, aligns/extends load data, and waits a
// bounded number of cycles for slow load responses.
//
// Ports:
//   clk_i, rstn_i            clock, async active-low reset
//   validM_i, operationM_i   instruction presented by the memory stage
//   rdM_addr_i, rdM_wrt_ena_i destination register and its write enable
//   resultM_i                ALU/link result, or effective byte address for loads
//   dmem_rsp_valid_i/_data_i load response pulse and raw aligned word
//   rdWB_port_o              registered {valid, addr, data} write port to decode
//   stallWB_o                combinational hold for memory stage and upstream
//   load_err_o               one-cycle pulse after a load timed out
//   instret_o                64-bit retired count (only with WB_INSTRET_EN)
//
// Optional feature macro: WB_INSTRET_EN adds the retired-instruction counter.

package riscv_pkg;
    localparam int XLEN = 32;

    typedef enum logic [4:0] {
        NOP, ADD, SUB, ADDI, LUI, AUIPC, JAL, JALR,
        LB, LH, LW, LBU, LHU, SB, SH, SW, BEQ, BNE
    } operation_e;

    typedef struct packed {
        logic            valid;
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
    } rd_port_t;
endpackage

// Purpose: retire one instruction per cycle and drive the decode write port.
// Latency: write port valid one cycle after completion; loads may wait up to LOAD_TIMEOUT cycles.
// Backpressure: stallWB_o holds upstream while a load response is outstanding.
module writeback
    import riscv_pkg::*;
#(
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            validM_i,
    input  operation_e      operationM_i,
    input  logic [4:0]      rdM_addr_i,
    input  logic            rdM_wrt_ena_i,
    input  logic [XLEN-1:0] resultM_i,
    input  logic            dmem_rsp_valid_i,
    input  logic [XLEN-1:0] dmem_rsp_data_i,
    output rd_port_t        rdWB_port_o,
    output logic            stallWB_o,
    output logic            load_err_o
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]     instret_o
`endif
);

    localparam logic [7:0] TIMEOUT_C = 8'(LOAD_TIMEOUT);

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    rd_port_t        rd_q;
    logic            err_q;
    logic            is_load;
    logic            complete;
    logic            timeout;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wb_data;

    assign is_load = operationM_i inside {LB, LH, LW, LBU, LHU};

    // Load alignment: byte lane by off, halfword lane by off[1], word ignores off.
    always_comb begin
        byte_sel  = 8'h00;
        half_sel  = resultM_i[1] ? dmem_rsp_data_i[31:16] : dmem_rsp_data_i[15:0];
        load_data = dmem_rsp_data_i;
        case (resultM_i[1:0])
            2'd0:    byte_sel = dmem_rsp_data_i[7:0];
            2'd1:    byte_sel = dmem_rsp_data_i[15:8];
            2'd2:    byte_sel = dmem_rsp_data_i[23:16];
            default: byte_sel = dmem_rsp_data_i[31:24];
        endcase
        case (operationM_i)
            LB:      load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LBU:     load_data = {{(XLEN-8){1'b0}}, byte_sel};
            LH:      load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            LHU:     load_data = {{(XLEN-16){1'b0}}, half_sel};
            default: load_data = dmem_rsp_data_i;
        endcase
    end

    // Next-state, completion and stall. A response in the cycle the counter
    // would hit the limit takes priority over the timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        complete  = 1'b0;
        timeout   = 1'b0;
        stallWB_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (validM_i) begin
                    if (!is_load || dmem_rsp_valid_i) begin
                        complete = 1'b1;
                    end else begin
                        state_d   = S_WAIT;
                        cnt_d     = 8'd0;
                        stallWB_o = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (dmem_rsp_valid_i) begin
                    complete = 1'b1;
                    cnt_d    = 8'd0;
                    state_d  = S_IDLE;
                end else if (cnt_q + 8'd1 == TIMEOUT_C) begin
                    complete = 1'b1;
                    timeout  = 1'b1;
                    cnt_d    = 8'd0;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d     = cnt_q + 8'd1;
                    stallWB_o = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wb_data = resultM_i;
        if (timeout) begin
            wb_data = '0;
        end else if (is_load) begin
            wb_data = load_data;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= timeout;
            rd_q.valid <= complete && rdM_wrt_ena_i && (rdM_addr_i != 5'd0);
            // addr/data hold between completions so decode sees a stable port.
            if (complete) begin
                rd_q.addr <= rdM_addr_i;
                rd_q.data <= wb_data;
            end
        end
    end

    assign rdWB_port_o = rd_q;
    assign load_err_o  = err_q;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    // Counts every completion, including stores, x0 writes and timed-out loads.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            instret_q <= 64'd0;
        end else if (complete) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret_o = instret_q;
`endif

endmodule

// File: tb/tb_writeback.sv
module tb_writeback;
    import riscv_pkg::*;

    logic            clk = 1'b0;
    logic            rstn;
    logic            validM;
    operation_e      opM;
    logic [4:0]      rdM;
    logic            wenM;
    logic [31:0]     resM;
    logic            rsp_vld;
    logic [31:0]     rsp_dat;
    rd_port_t        rd_port;
    logic            stall;
    logic            load_err;
`ifdef WB_INSTRET_EN
    logic [63:0]     instret;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    writeback #(.LOAD_TIMEOUT(15)) dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .validM_i         (validM),
        .operationM_i     (opM),
        .rdM_addr_i       (rdM),
        .rdM_wrt_ena_i    (wenM),
        .resultM_i        (resM),
        .dmem_rsp_valid_i (rsp_vld),
        .dmem_rsp_data_i  (rsp_dat),
        .rdWB_port_o      (rd_port),
        .stallWB_o        (stall),
        .load_err_o       (load_err)
`ifdef WB_INSTRET_EN
        ,
        .instret_o        (instret)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Presents a load and steps cycle by cycle until a non-stalled cycle
    // (completion). rsp_at < 0 means no response is ever given.
    task automatic run_load(input operation_e op, input logic [4:0] rd, input logic [31:0] res,
                            input int rsp_at, input logic [31:0] rdata,
                            output int stalls, output int done_at,
                            output logic [37:0] port, output logic err, output logic early);
        logic stall_now;
        stalls  = 0;
        done_at = -1;
        port    = '0;
        err     = 1'b0;
        early   = 1'b0;
        validM  = 1'b1;
        opM     = op;
        rdM     = rd;
        wenM    = 1'b1;
        resM    = res;
        for (int c = 0; c < 40; c++) begin
            rsp_vld = (c == rsp_at);
            rsp_dat = (c == rsp_at) ? rdata : 32'h0;
            #1;
            stall_now = stall;
            if (stall_now) stalls++;
            @(negedge clk);
            if (!stall_now) begin
                done_at = c;
                port    = rd_port;
                err     = load_err;
                break;
            end
            if (rd_port.valid || load_err) early = 1'b1;
        end
        validM  = 1'b0;
        rsp_vld = 1'b0;
        rsp_dat = 32'h0;
    endtask

    typedef struct {
        operation_e  op;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] res;
        logic        rv;
        logic [31:0] rdat;
        logic [37:0] exp_port;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    int          stalls, done_at;
    logic [37:0] port;
    logic        err, early;

    initial begin
        vecs[0]  = '{ADDI, 5'd5,  1'b1, 32'h0000_0042, 1'b0, 32'h0,          {1'b1, 5'd5,  32'h0000_0042}};
        vecs[1]  = '{ADDI, 5'd0,  1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,          {1'b0, 5'd0,  32'hDEAD_BEEF}};
        vecs[2]  = '{LB,   5'd1,  1'b1, 32'h0000_1003, 1'b1, 32'h807F_FF80, {1'b1, 5'd1,  32'hFFFF_FF80}};
        vecs[3]  = '{LBU,  5'd2,  1'b1, 32'h0000_1000, 1'b1, 32'h807F_FF80, {1'b1, 5'd2,  32'h0000_0080}};
        vecs[4]  = '{LH,   5'd3,  1'b1, 32'h0000_1002, 1'b1, 32'h807F_FF80, {1'b1, 5'd3,  32'hFFFF_807F}};
        vecs[5]  = '{LHU,  5'd4,  1'b1, 32'h0000_1001, 1'b1, 32'h807F_FF80, {1'b1, 5'd4,  32'h0000_FF80}};
        vecs[6]  = '{LW,   5'd6,  1'b1, 32'h0000_1002, 1'b1, 32'h807F_FF80, {1'b1, 5'd6,  32'h807F_FF80}};
        vecs[7]  = '{LB,   5'd8,  1'b1, 32'h0000_2001, 1'b1, 32'h1234_5678, {1'b1, 5'd8,  32'h0000_0056}};
        vecs[8]  = '{LB,   5'd9,  1'b1, 32'h0000_2002, 1'b1, 32'h12A4_5678, {1'b1, 5'd9,  32'hFFFF_FFA4}};
        vecs[9]  = '{LHU,  5'd10, 1'b1, 32'h0000_2003, 1'b1, 32'hABCD_1234, {1'b1, 5'd10, 32'h0000_ABCD}};
        vecs[10] = '{LH,   5'd11, 1'b1, 32'h0000_2000, 1'b1, 32'h0000_8001, {1'b1, 5'd11, 32'hFFFF_8001}};
        vecs[11] = '{SW,   5'd12, 1'b0, 32'h0000_2000, 1'b1, 32'h0000_0000, {1'b0, 5'd12, 32'h0000_2000}};
        vecs[12] = '{LW,   5'd0,  1'b1, 32'h0000_0010, 1'b1, 32'h0000_0055, {1'b0, 5'd0,  32'h0000_0055}};
        vecs[13] = '{JAL,  5'd1,  1'b1, 32'h0000_0104, 1'b1, 32'hFFFF_FFFF, {1'b1, 5'd1,  32'h0000_0104}};

        rstn    = 1'b0;
        validM  = 1'b0;
        opM     = NOP;
        rdM     = 5'd0;
        wenM    = 1'b0;
        resM    = 32'h0;
        rsp_vld = 1'b0;
        rsp_dat = 32'h0;

        // Reset state
        #1;
        check("reset_port", rd_port, 38'h0);
        check("reset_err", load_err, 1'b0);
        check("reset_stall", stall, 1'b0);
`ifdef WB_INSTRET_EN
        check("reset_instret", instret, 64'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Single-cycle completions
        for (int i = 0; i < NV; i++) begin
            validM  = 1'b1;
            opM     = vecs[i].op;
            rdM     = vecs[i].rd;
            wenM    = vecs[i].wen;
            resM    = vecs[i].res;
            rsp_vld = vecs[i].rv;
            rsp_dat = vecs[i].rdat;
            #1;
            check($sformatf("vec%0d_stall", i), stall, 1'b0);
            @(negedge clk);
            check($sformatf("vec%0d_port", i), rd_port, vecs[i].exp_port);
            check($sformatf("vec%0d_err", i), load_err, 1'b0);
        end
        validM  = 1'b0;
        rsp_vld = 1'b0;
        @(negedge clk);
        check("hold_port", rd_port, {1'b0, 5'd1, 32'h0000_0104});
`ifdef WB_INSTRET_EN
        check("instret_table", instret, 64'd14);
`endif

        // Stray response in IDLE with nothing pending
        rsp_vld = 1'b1;
        rsp_dat = 32'h1111_2222;
        #1;
        check("stray_rsp_stall", stall, 1'b0);
        @(negedge clk);
        rsp_vld = 1'b0;
        check("stray_rsp_port", rd_port, {1'b0, 5'd1, 32'h0000_0104});

        // LW to x7, response after 4 cycles
        run_load(LW, 5'd7, 32'h0000_3000, 4, 32'h1234_5678, stalls, done_at, port, err, early);
        check("wait4_stalls", stalls, 4);
        check("wait4_done", done_at, 4);
        check("wait4_port", port, {1'b1, 5'd7, 32'h1234_5678});
        check("wait4_err", err, 1'b0);
        check("wait4_early", early, 1'b0);

        // No response: timeout after 15 stall cycles
        run_load(LW, 5'd9, 32'h0000_4000, -1, 32'h0, stalls, done_at, port, err, early);
        check("tmo_stalls", stalls, 15);
        check("tmo_done", done_at, 15);
        check("tmo_port", port, {1'b1, 5'd9, 32'h0});
        check("tmo_err", err, 1'b1);
        check("tmo_early", early, 1'b0);
        @(negedge clk);
        check("tmo_err_pulse", load_err, 1'b0);
        @(negedge clk);
        rsp_vld = 1'b1;
        rsp_dat = 32'hFFFF_FFFF;
        #1;
        check("late_rsp_stall", stall, 1'b0);
        @(negedge clk);
        rsp_vld = 1'b0;
        check("late_rsp_port", rd_port, {1'b0, 5'd9, 32'h0});
        check("late_rsp_err", load_err, 1'b0);

        // Response in the same cycle the counter would time out
        run_load(LW, 5'd10, 32'h0000_5000, 15, 32'hCAFE_F00D, stalls, done_at, port, err, early);
        check("edge_stalls", stalls, 15);
        check("edge_port", port, {1'b1, 5'd10, 32'hCAFE_F00D});
        check("edge_err", err, 1'b0);

        // Reset in WAIT
        validM  = 1'b1;
        opM     = LW;
        rdM     = 5'd11;
        wenM    = 1'b1;
        resM    = 32'h0000_6000;
        repeat (3) @(negedge clk);
        #1;
        check("rst_pre_stall", stall, 1'b1);
        rstn   = 1'b0;
        validM = 1'b0;
        #1;
        check("rst_port", rd_port, 38'h0);
        check("rst_err", load_err, 1'b0);
        check("rst_stall", stall, 1'b0);
`ifdef WB_INSTRET_EN
        check("rst_instret", instret, 64'd0);
`endif
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_no_write", rd_port, 38'h0);
        check("rst_no_err", load_err, 1'b0);
        validM = 1'b1;
        opM    = ADDI;
        rdM    = 5'd5;
        wenM   = 1'b1;
        resM   = 32'h0000_0077;
        #1;
        check("post_rst_stall", stall, 1'b0);
        @(negedge clk);
        validM = 1'b0;
        check("post_rst_port", rd_port, {1'b1, 5'd5, 32'h0000_0077});
`ifdef WB_INSTRET_EN
        check("post_rst_instret", instret, 64'd1);
`endif
        run_load(LW, 5'd12, 32'h0000_7000, 2, 32'hA5A5_A5A5, stalls, done_at, port, err, early);
        check("post_rst_ld_stalls", stalls, 2);
        check("post_rst_ld_port", port, {1'b1, 5'd12, 32'hA5A5_A5A5});
        check("post_rst_ld_err", err, 1'b0);
`ifdef WB_INSTRET_EN
        check("final_instret", instret, 64'd2);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
